// File: rtl/im_pkg.sv
// Shared constants and state encoding for the instruction-memory loader and the instruction memory.
// Widths/depth here are the defaults both sides agree on.
package im_pkg;

    localparam int BYTE_W    = 8;
    localparam int IM_ADDR_W = 16;
    localparam int IM_DEPTH  = 23;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        LOAD = 3'd2,
        CHK  = 3'd3,
        FIN  = 3'd4,
        FAIL = 3'd5
    } state_t;

endpackage

// File: rtl/im_loader.sv
// Purpose: streams a length-prefixed byte frame into the instruction memory write port; holds the CPU while loading.
// Latency: one cycle from the accepting edge to the mem_we pulse; back-to-back bytes give back-to-back writes.
// Backpressure: in_ready is a decode of the registered state (no in_valid path); optional IM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module im_loader
    import im_pkg::*;
#(
    parameter int ADDR_W    = IM_ADDR_W,
    parameter int MEM_DEPTH = IM_DEPTH,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = CHK;
`else
    localparam state_t AFTER_PAYLOAD = FIN;
`endif

    state_t            state_q;
    state_t            state_d;
    logic [BYTE_W-1:0] len_q;
    logic [BYTE_W-1:0] idx_q;
    logic              xfer;
    logic              last_byte;
    logic              len_over;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q;
    logic              chk_bad_q;
`endif

    assign in_ready  = (state_q == LEN) || (state_q == LOAD) || (state_q == CHK);
    assign xfer      = in_valid && in_ready;
    assign last_byte = (idx_q + 8'd1) == len_q;
    assign len_over  = {24'd0, in_data} > $unsigned(MEM_DEPTH);
    assign cpu_hold  = busy;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = LEN;
            LEN: begin
                if (xfer) begin
                    if (in_data == 8'd0) state_d = AFTER_PAYLOAD;
                    else if (len_over)   state_d = FAIL;
                    else                 state_d = LOAD;
                end
            end
            LOAD:    if (xfer && last_byte) state_d = AFTER_PAYLOAD;
            CHK:     if (xfer) state_d = FIN;
            FIN:     state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags change on the edge leaving FIN/FAIL, so the last write is seen while cpu_hold is still high.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len_q     <= '0;
            idx_q     <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
            chk_bad_q <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err   <= 1'b0;
                        idx_q <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
                        xor_q     <= '0;
                        chk_bad_q <= 1'b0;
`endif
                    end
                end
                LEN: if (xfer) len_q <= in_data;
                LOAD: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                        mem_wdata <= in_data;
                        idx_q     <= idx_q + 8'd1;
`ifdef IM_LOADER_CHECKSUM_EN
                        xor_q     <= xor_q ^ in_data;
`endif
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                CHK: if (xfer) chk_bad_q <= (xor_q ^ in_data) != 8'd0;
`endif
                FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
                    err  <= chk_bad_q;
`endif
                end
                FAIL: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    err  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed frames into im_loader; expected writes are queued at acceptance and a negedge monitor pops/compares each mem_we pulse.
module tb_im_loader;
    import im_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, busy, done, err, cpu_hold;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    always #5 clk = ~clk;

    im_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          when;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_wr_cyc = -1;

`ifdef IM_LOADER_CHECKSUM_EN
    localparam int FALL_OFS = 2;
`else
    localparam int FALL_OFS = 1;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {16'd0, mem_addr}, {16'd0, mon_e.addr});
                check("wr_data", {24'd0, mem_wdata}, {24'd0, mon_e.data});
                check("wr_latency", cyc, mon_e.when);
                check("wr_under_hold", {31'd0, cpu_hold}, 32'd1);
            end
            last_wr_cyc = cyc;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents b and returns #1 after the edge that accepts it.
    task automatic send(input logic [7:0] b, input bit payload, input logic [15:0] addr);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            if (payload) exp_q.push_back('{addr, b, cyc + 1});
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int ofs);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
        else if (ofs > 0) check("busy_fall", cyc, last_wr_cyc + ofs);
        check("hold_eq_busy", {31'd0, cpu_hold}, {31'd0, busy});
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bp_bytes [4];
        bp_bytes[0] = 8'h01; bp_bytes[1] = 8'h2F; bp_bytes[2] = 8'h01; bp_bytes[3] = 8'h2E;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);

        // Valid without start must not be consumed.
        rst = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;

        // Basic load, valid held high.
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        send(8'h04, 1'b0, 16'd0);
        check("load_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        send(8'h01, 1'b1, 16'd0);
        send(8'h2F, 1'b1, 16'd1);
        send(8'h01, 1'b1, 16'd2);
        send(8'h2E, 1'b1, 16'd3);
`ifdef IM_LOADER_CHECKSUM_EN
        send(8'h01, 1'b0, 16'd0);
`endif
        in_valid = 1'b0;
        wait_idle(FALL_OFS);
        check("basic_done", {31'd0, done}, 32'd1);
        check("basic_err", {31'd0, err}, 32'd0);
        check("basic_all_written", exp_q.size(), 32'd0);

        // Same frame with gaps in in_valid and a start pulse mid-frame that must be ignored.
        pulse_start();
        send(8'h04, 1'b0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0;
            if (i == 2) pulse_start();
            else begin @(posedge clk); #1; end
            send(bp_bytes[i], 1'b1, 16'(i));
        end
`ifdef IM_LOADER_CHECKSUM_EN
        send(8'h01, 1'b0, 16'd0);
`endif
        in_valid = 1'b0;
        wait_idle(0);
        check("bp_done", {31'd0, done}, 32'd1);
        check("bp_err", {31'd0, err}, 32'd0);
        check("bp_all_written", exp_q.size(), 32'd0);

        // Length overflow: 24 > 23.
        pulse_start();
        send(8'h18, 1'b0, 16'd0);
        in_valid = 1'b0;
        check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
        wait_idle(0);
        check("ovf_err", {31'd0, err}, 32'd1);
        check("ovf_done", {31'd0, done}, 32'd0);
        check("ovf_busy", {31'd0, busy}, 32'd0);

        // Empty frame.
        pulse_start();
        send(8'h00, 1'b0, 16'd0);
`ifdef IM_LOADER_CHECKSUM_EN
        send(8'h00, 1'b0, 16'd0);
`endif
        in_valid = 1'b0;
        wait_idle(0);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_err", {31'd0, err}, 32'd0);

        // Reset after 3 of 6 payload bytes.
        pulse_start();
        send(8'h06, 1'b0, 16'd0);
        send(8'h11, 1'b1, 16'd0);
        send(8'h22, 1'b1, 16'd1);
        send(8'h33, 1'b1, 16'd2);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_addr", {16'd0, mem_addr}, 32'd0);
        check("mid_rst_three_writes", exp_q.size(), 32'd0);
        pulse_start();
        send(8'h01, 1'b0, 16'd0);
        send(8'h5A, 1'b1, 16'd0);
`ifdef IM_LOADER_CHECKSUM_EN
        send(8'h5A, 1'b0, 16'd0);
`endif
        in_valid = 1'b0;
        wait_idle(FALL_OFS);
        check("post_rst_done", {31'd0, done}, 32'd1);

`ifdef IM_LOADER_CHECKSUM_EN
        pulse_start();
        send(8'h02, 1'b0, 16'd0);
        send(8'h05, 1'b1, 16'd0);
        send(8'h61, 1'b1, 16'd1);
        send(8'h64, 1'b0, 16'd0);
        in_valid = 1'b0;
        wait_idle(FALL_OFS);
        check("ck_good_done", {31'd0, done}, 32'd1);
        check("ck_good_err", {31'd0, err}, 32'd0);

        pulse_start();
        send(8'h02, 1'b0, 16'd0);
        send(8'h05, 1'b1, 16'd0);
        send(8'h61, 1'b1, 16'd1);
        send(8'h65, 1'b0, 16'd0);
        in_valid = 1'b0;
        wait_idle(FALL_OFS);
        check("ck_bad_done", {31'd0, done}, 32'd1);
        check("ck_bad_err", {31'd0, err}, 32'd1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
